// File: rtl/fre_calc_pkg.sv
// Shared constants, FSM encodings and the rounding pre-add for the frequency calculator.
package fre_calc_pkg;

  localparam int unsigned CLK_HZ_DEF = 100_000_000;
  localparam int          DIV_W      = 64;
  localparam int          IN_W       = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Adding M/2 before the truncating divide turns floor() into round-to-nearest.
  function automatic logic [DIV_W-1:0] round_num(input logic [IN_W-1:0] n,
                                                 input logic [IN_W-1:0] m,
                                                 input logic [IN_W-1:0] clk_hz);
    return (DIV_W'(n) * DIV_W'(clk_hz)) + DIV_W'(m >> 1);
  endfunction

endpackage

// File: rtl/fre_calc_if.sv
// Gate-count inputs and frequency result outputs of fre_calc.
interface fre_calc_if;
  import fre_calc_pkg::*;

  logic [IN_W-1:0] m;
  logic [IN_W-1:0] n;
  logic [IN_W-1:0] freq_hz;
  logic            freq_valid;
  logic            busy;
  logic            div_zero;
  logic            sat;

  modport master (output m, n, input freq_hz, freq_valid, busy, div_zero, sat);
  modport slave  (input m, n, output freq_hz, freq_valid, busy, div_zero, sat);
endinterface

// File: rtl/fre_calc_udiv.sv
// Restoring unsigned divider, 64b / 32b, one quotient bit per cycle MSB first, fixed 64-cycle latency.
module fre_calc_udiv
  import fre_calc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_num,
  input  logic [IN_W-1:0]  i_den,
  output logic             o_done,
  output logic [DIV_W-1:0] o_quot
);

  logic [DIV_W-1:0] r_q;
  logic [IN_W-1:0]  r_rem;
  logic [IN_W-1:0]  r_den;
  logic [5:0]       r_cnt;
  logic             r_busy;

  logic [IN_W:0]    w_trial;
  logic [IN_W-1:0]  w_diff;
  logic             w_ge;

  // Remainder stays below den < 2^32, so the 33-bit trial only needs 32 bits after subtracting.
  assign w_trial = {r_rem, r_q[DIV_W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial[IN_W-1:0] - r_den;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_q    <= i_num;
      r_rem  <= '0;
      r_den  <= i_den;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_q   <= {r_q[DIV_W-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_trial[IN_W-1:0];
      r_cnt <= r_cnt + 6'd1;
      if (r_cnt == 6'(DIV_W-1)) r_busy <= 1'b0;
    end
  end

  // High during the edge that shifts in the last quotient bit.
  assign o_done = r_busy && (r_cnt == 6'(DIV_W-1));
  assign o_quot = r_q;

endmodule

// File: rtl/fre_calc.sv
// Turns gate counts {M,N} into a rounded frequency word; recomputes only on change, keeps latest pair.
module fre_calc
  import fre_calc_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
  input  logic     i_clk_100M,
  input  logic     i_rst,
  fre_calc_if.slave s_if
);

  logic [1:0]      r_state;
  logic [IN_W-1:0] r_m_s;
  logic [IN_W-1:0] r_n_s;
  logic            r_pending;
  logic [IN_W-1:0] r_freq_hz;
  logic            r_freq_valid;
  logic            r_div_zero;
  logic            r_sat;

  logic            w_new;
  logic            w_start;
  logic            w_div_done;
  logic [DIV_W-1:0] w_quot;

  assign w_new   = ({s_if.m, s_if.n} != {r_m_s, r_n_s});
  assign w_start = (r_state == S_LOAD) && (r_m_s != '0);

  fre_calc_udiv u_div (
    .i_clk   (i_clk_100M),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_num   (round_num(r_n_s, r_m_s, IN_W'(CLK_HZ))),
    .i_den   (r_m_s),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge i_clk_100M) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_m_s        <= '0;
      r_n_s        <= '0;
      r_pending    <= 1'b0;
      r_freq_hz    <= '0;
      r_freq_valid <= 1'b0;
      r_div_zero   <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      // Shadow is frozen while busy; a change only leaves a flag so IDLE recaptures the latest pair.
      if ((r_state != S_IDLE) && w_new) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_new || r_pending) begin
            r_m_s     <= s_if.m;
            r_n_s     <= s_if.n;
            r_pending <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: r_state <= (r_m_s == '0) ? S_DONE : S_DIV;
        S_DIV:  if (w_div_done) r_state <= S_DONE;
        S_DONE: begin
          r_freq_valid <= 1'b1;
          if (r_m_s == '0) begin
            r_freq_hz  <= '0;
            r_div_zero <= 1'b1;
            r_sat      <= 1'b0;
          end else begin
            r_div_zero <= 1'b0;
            r_sat      <= (w_quot[DIV_W-1:IN_W] != '0);
            r_freq_hz  <= (w_quot[DIV_W-1:IN_W] != '0) ? '1 : w_quot[IN_W-1:0];
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.freq_hz    = r_freq_hz;
  assign s_if.freq_valid = r_freq_valid;
  assign s_if.busy       = (r_state != S_IDLE);
  assign s_if.div_zero   = r_div_zero;
  assign s_if.sat        = r_sat;

endmodule

// File: tb/tb_fre_calc.sv
// Directed bench for fre_calc: latency, rounding, divide-by-zero, saturation, pending recapture, reset abort.
module tb_fre_calc;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fre_calc_if bus ();

  fre_calc #(.CLK_HZ(100_000_000)) dut (
    .i_clk_100M (clk),
    .i_rst      (rst),
    .s_if       (bus)
  );

  // Drive a pair right after an edge and count edges after the capture edge until freq_valid.
  task automatic run_pair(input logic [31:0] m, input logic [31:0] n,
                          output int lat, output logic [31:0] f,
                          output logic dz, output logic st, output logic busy0);
    bus.m = m;
    bus.n = n;
    lat   = -1;
    f     = '0;
    dz    = 1'b0;
    st    = 1'b0;
    busy0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 0) busy0 = bus.busy;
      if (bus.freq_valid) begin
        lat = i;
        f   = bus.freq_hz;
        dz  = bus.div_zero;
        st  = bus.sat;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m = '0;
    bus.n = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (bus.freq_hz !== 32'd0)  begin errors++; $display("FAIL reset_freq got %0d expected 0", bus.freq_hz); end
    if (bus.freq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.freq_valid); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    if (bus.div_zero !== 1'b0)   begin errors++; $display("FAIL reset_dz got %b expected 0", bus.div_zero); end
    if (bus.sat !== 1'b0)        begin errors++; $display("FAIL reset_sat got %b expected 0", bus.sat); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] f; logic dz, st, b0;
    run_pair(32'd100_000_000, 32'd1_000, lat, f, dz, st, b0);
    checks += 5;
    if (lat !== 66)       begin errors++; $display("FAIL basic_latency got %0d expected 66", lat); end
    if (f !== 32'd1_000)  begin errors++; $display("FAIL basic_freq got %0d expected 1000", f); end
    if (dz !== 1'b0)      begin errors++; $display("FAIL basic_dz got %b expected 0", dz); end
    if (st !== 1'b0)      begin errors++; $display("FAIL basic_sat got %b expected 0", st); end
    if (b0 !== 1'b1)      begin errors++; $display("FAIL basic_busy got %b expected 1", b0); end
    @(posedge clk); #1;
    checks++;
    if (bus.freq_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b expected 0", bus.freq_valid); end
  endtask

  task automatic test_rounding();
    int lat; logic [31:0] f; logic dz, st, b0;
    run_pair(32'd50_000_007, 32'd3, lat, f, dz, st, b0);
    checks += 2;
    if (f !== 32'd6)   begin errors++; $display("FAIL round_6hz got %0d expected 6", f); end
    if (lat !== 66)    begin errors++; $display("FAIL round_6hz_latency got %0d expected 66", lat); end
    run_pair(32'd3, 32'd1, lat, f, dz, st, b0);
    checks++;
    if (f !== 32'd33_333_333) begin errors++; $display("FAIL round_third got %0d expected 33333333", f); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] f; logic dz, st, b0;
    run_pair(32'd0, 32'd5, lat, f, dz, st, b0);
    checks += 4;
    if (lat !== 2)     begin errors++; $display("FAIL dz_latency got %0d expected 2", lat); end
    if (f !== 32'd0)   begin errors++; $display("FAIL dz_freq got %0d expected 0", f); end
    if (dz !== 1'b1)   begin errors++; $display("FAIL dz_flag got %b expected 1", dz); end
    if (st !== 1'b0)   begin errors++; $display("FAIL dz_sat got %b expected 0", st); end
    run_pair(32'd3, 32'd1, lat, f, dz, st, b0);
    checks += 2;
    if (dz !== 1'b0)          begin errors++; $display("FAIL dz_clear got %b expected 0", dz); end
    if (f !== 32'd33_333_333) begin errors++; $display("FAIL dz_clear_freq got %0d expected 33333333", f); end
  endtask

  task automatic test_sat();
    int lat; logic [31:0] f; logic dz, st, b0;
    run_pair(32'd1, 32'd100, lat, f, dz, st, b0);
    checks += 3;
    if (f !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_freq got %h expected ffffffff", f); end
    if (st !== 1'b1)         begin errors++; $display("FAIL sat_flag got %b expected 1", st); end
    if (lat !== 66)          begin errors++; $display("FAIL sat_latency got %0d expected 66", lat); end
  endtask

  task automatic test_no_recompute();
    int pulses = 0;
    int busy_cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.freq_valid) pulses++;
      if (bus.busy) busy_cnt++;
    end
    checks += 2;
    if (pulses !== 0)   begin errors++; $display("FAIL same_pair_pulses got %0d expected 0", pulses); end
    if (busy_cnt !== 0) begin errors++; $display("FAIL same_pair_busy got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [31:0] v0 = '0;
    logic [31:0] v1 = '0;
    bus.m = 32'd1_000; bus.n = 32'd7;
    repeat (10) @(posedge clk); #1;
    bus.m = 32'd5;     bus.n = 32'd1;
    repeat (10) @(posedge clk); #1;
    bus.m = 32'd6;     bus.n = 32'd1;
    repeat (10) @(posedge clk); #1;
    bus.m = 32'd4;     bus.n = 32'd9;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.freq_valid) begin
        if (pulses == 0) v0 = bus.freq_hz;
        if (pulses == 1) v1 = bus.freq_hz;
        pulses++;
      end
    end
    checks += 4;
    if (pulses !== 2)           begin errors++; $display("FAIL b2b_pulses got %0d expected 2", pulses); end
    if (v0 !== 32'd700_000)     begin errors++; $display("FAIL b2b_first got %0d expected 700000", v0); end
    if (v1 !== 32'd225_000_000) begin errors++; $display("FAIL b2b_last got %0d expected 225000000", v1); end
    if (bus.sat !== 1'b0)       begin errors++; $display("FAIL b2b_sat_clear got %b expected 0", bus.sat); end
  endtask

  task automatic test_reset_mid_div();
    int lat; logic [31:0] f; logic dz, st, b0;
    int early = 0;
    bus.m = 32'd200; bus.n = 32'd3;
    repeat (32) begin
      @(posedge clk); #1;
      if (bus.freq_valid) early++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (bus.freq_hz !== 32'd0)   begin errors++; $display("FAIL abort_freq got %0d expected 0", bus.freq_hz); end
    if (bus.freq_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b expected 0", bus.freq_valid); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b expected 0", bus.busy); end
    if (bus.div_zero !== 1'b0 || bus.sat !== 1'b0)
      begin errors++; $display("FAIL abort_flags got %b%b expected 00", bus.div_zero, bus.sat); end
    if (early !== 0)             begin errors++; $display("FAIL abort_early_valid got %0d expected 0", early); end
    rst = 1'b0;
    run_pair(32'd200, 32'd3, lat, f, dz, st, b0);
    checks += 2;
    if (lat !== 66)            begin errors++; $display("FAIL abort_recompute_latency got %0d expected 66", lat); end
    if (f !== 32'd1_500_000)   begin errors++; $display("FAIL abort_recompute_freq got %0d expected 1500000", f); end
  endtask

  initial begin
    rst   = 1'b1;
    bus.m = '0;
    bus.n = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_div_zero();
    test_sat();
    test_no_recompute();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
